mem_stage_pipe: RTL and testbench
=================================

// Module: mem_stage_pipe
// PURPOSE
// - Parametrised EX->MEM->WB pipeline stage for the ASIP datapath.
// - Generalises the fixed 16-bit / 13-bit-address memory stage with three additions:
//   - valid/ready backpressure on both sides;
//   - a variable-latency data-memory req/gnt/rvalid interface;
//   - flush with drop of in-flight responses.
// - Registers ALU result, load data and writeback controls for the WB stage.
// PARAMETERS
// - ARQ        16  datapath width (bits)
// - ADDR_W     13  data-memory word-address width
// - REG_W       4  register-file destination index width
// PORTS
// - clk              in   1       clock, rising edge
// - rst_n            in   1       async active-low reset
// - flush            in   1       sync kill of the held op and of any in-flight load
// - ex_valid         in   1       EX presents an op
// - ex_ready         out  1       stage can accept an op this cycle
// - ex_op            in   2       mem_op_t: OP_PASS=0, OP_LOAD=1, OP_STORE=2
// - ex_alu_result    in   ARQ     ALU result; ex_alu_result[ADDR_W-1:0] is the mem address
// - ex_store_data    in   ARQ     store data
// - ex_rd            in   REG_W   destination register
// - ex_wb_en         in   1       writeback enable
// - ex_pc_en         in   1       PC enable carried to WB
// - dm_req           out  1       memory request, held until dm_gnt
// - dm_we            out  1       1 = write
// - dm_addr          out  ADDR_W  word address
// - dm_wdata         out  ARQ     write data
// - dm_gnt           in   1       request accepted this cycle
// - dm_rvalid        in   1       read data valid; one per granted read, in order
// - dm_rdata         in   ARQ     read data
// - wb_valid         out  1       WB bundle valid
// - wb_ready         in   1       WB consumes the bundle
// - wb_mux_contrl    out  1       1 = select mem_result, 0 = select alu_result
// - wb_enable        out  1       register write enable
// - wb_pc_en         out  1       PC enable
// - wb_rd            out  REG_W   destination register
// - wb_alu_result    out  ARQ     registered ALU result
// - wb_mem_result    out  ARQ     registered load data; 0 for non-loads
// BEHAVIOUR
// - Reset (async, rst_n=0): every output 0, except ex_ready=1. FSM goes to S_IDLE.
//   Reset mid-transaction abandons it; a later dm_rvalid arriving in S_IDLE is ignored.
// - FSM states: S_IDLE, S_REQ, S_WAIT, S_OUT.
// - ex_ready = (state==S_IDLE) | (state==S_OUT & wb_ready). An op is accepted on ex_valid & ex_ready.
// - Accepted OP_PASS goes to S_OUT next cycle: 1-cycle latency, wb_mux_contrl=0.
// - Accepted LOAD/STORE: dm_req=1 the next cycle, with dm_addr/dm_we/dm_wdata from a
//   registered copy of the op; state S_REQ.
//   - dm_req and its payload stay stable until dm_gnt.
// - S_REQ & dm_gnt:
//   - STORE goes to S_OUT with wb_mux_contrl=0 and wb_enable forced 0.
//   - LOAD goes to S_WAIT.
// - S_WAIT & dm_rvalid: capture dm_rdata into wb_mem_result, wb_mux_contrl=1, go to S_OUT.
//   - dm_rvalid in the grant cycle is legal (0-wait memory) and is captured in that cycle.
// - S_OUT: wb_valid=1 and all wb_* outputs stable until wb_ready.
//   - If wb_ready & ex_valid in the same cycle, the next op is accepted back-to-back.
//     Throughput is 1 op/cycle for PASS; no bubble.
//   - If wb_ready & !ex_valid, go to S_IDLE and drop wb_valid.
// - Minimum latencies, accept to wb_valid:
//   - PASS: 1 cycle.
//   - LOAD: 2 cycles plus grant wait plus rvalid wait.
// - flush (priority over every other event in its cycle):
//   - Drops the held op; wb_valid=0 next cycle; state goes to S_IDLE.
//   - An ex op presented in the flush cycle is not accepted (ex_ready=0 while flush=1).
//   - Flush in S_REQ: dm_req drops next cycle. A grant seen in the flush cycle is treated as a
//     read whose response is owed; for a write, that grant completes the write.
//   - Flush in S_WAIT, or in S_REQ with dm_gnt on a read: one owed rvalid is counted in a
//     1-bit drop flag.
//     - That rvalid is discarded and never reaches wb_*.
//     - While the drop flag is set, ex_ready=0 for LOADs only; PASS and STORE are still accepted.
// - Widths: dm_addr is ex_alu_result[ADDR_W-1:0]; upper bits are ignored.
//   ADDR_W must be <= ARQ; elaboration $error otherwise.
// - Only one memory transaction is outstanding at a time.
// STRUCTURE
// - mem_stage_pkg holds: mem_op_t (2-bit enum), mem_state_t, OP_* constants.
// - One sub-module, mem_stage_fsm: state register, drop flag, ready/valid/req decode.
//   The datapath registers stay in mem_stage_pipe.
// TESTING
// - Reset: rst_n=0 with dm_rvalid=1 -> all outputs 0, ex_ready=1.
//   Release -> no wb_valid.
// - PASS back-to-back: ops alu=17, 18, 19 with wb_ready=1 -> wb_valid on 3 consecutive
//   cycles, wb_alu_result 17, 18, 19, wb_mux_contrl=0.
// - LOAD addr 0x0005, dm_gnt after 2 cycles, rvalid +3 cycles with rdata 0xBEEF ->
//   - dm_req stable for 3 cycles;
//   - wb_mem_result=0xBEEF, wb_mux_contrl=1, wb_enable=ex_wb_en.
// - STORE addr 0x1FFF, data 0x1234, plus alu bits [15:13]=3'b111 ->
//   - dm_addr=0x1FFF, dm_we=1, dm_wdata=0x1234;
//   - WB bundle with wb_enable=0.
// - Backpressure: wb_ready=0 for 4 cycles in S_OUT -> wb_* unchanged, ex_ready=0.
//   wb_ready=1 with ex_valid -> accepted in the same cycle.
// - Flush in S_WAIT, then a late rvalid with 0xDEAD, then a LOAD returning 0x0042 ->
//   0xDEAD never appears on wb_*; wb_mem_result=0x0042.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the EX->MEM->WB memory stage: op encoding and FSM states.
// OP_PASS/OP_LOAD/OP_STORE are the op constants used by the stage and its FSM.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_LOAD  = 2'd1,
        OP_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } mem_state_t;

    function automatic logic is_mem_op(input mem_op_t op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/mem_stage_fsm.sv
// Control for the memory stage: state register, owed-response drop flag and
// the ready/valid/req decode. The datapath registers live in mem_stage_pipe.
module mem_stage_fsm
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    flush,
    input  logic    ex_valid,
    input  mem_op_t ex_op,
    input  mem_op_t held_op,
    input  logic    wb_ready,
    input  logic    dm_gnt,
    input  logic    dm_rvalid,
    output logic    ex_ready,
    output logic    accept,
    output logic    capture,
    output logic    dm_req,
    output logic    wb_valid
);

    mem_state_t state_q, state_d;
    logic       drop_q, drop_d;
    logic       owed_read;

    // While a flushed read's response is still owed, a new load would be
    // unable to tell its own rvalid from the stale one, so only loads wait.
    assign ex_ready = !flush
                   && !(drop_q && ex_op == OP_LOAD)
                   && (state_q == S_IDLE || (state_q == S_OUT && wb_ready));
    assign accept   = ex_valid && ex_ready;

    assign owed_read = (held_op == OP_LOAD)
                    && (state_q == S_WAIT || (state_q == S_REQ && dm_gnt));
    assign capture   = !flush && owed_read && dm_rvalid;
    assign dm_req    = (state_q == S_REQ);
    assign wb_valid  = (state_q == S_OUT);

    always_comb begin
        // NOTE: defaults first so every path assigns state_d/drop_d and no latch is inferred.
        state_d = state_q;
        drop_d  = drop_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = is_mem_op(ex_op) ? S_REQ : S_OUT;
            end
            S_REQ: begin
                if (dm_gnt) state_d = (held_op == OP_LOAD && !dm_rvalid) ? S_WAIT : S_OUT;
            end
            S_WAIT: begin
                if (dm_rvalid) state_d = S_OUT;
            end
            S_OUT: begin
                if (wb_ready) begin
                    if (accept) state_d = is_mem_op(ex_op) ? S_REQ : S_OUT;
                    else        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drop_q && dm_rvalid) drop_d = 1'b0;

        if (flush) begin
            state_d = S_IDLE;
            if (owed_read && !dm_rvalid) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every register updating from pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: rtl/mem_stage_pipe.sv
// EX->MEM->WB pipeline stage with valid/ready on both sides, a req/gnt/rvalid
// data-memory port and flush that discards an in-flight load response.
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int ARQ    = 16,
    parameter int ADDR_W = 13,
    parameter int REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_op,
    input  logic [ARQ-1:0]    ex_alu_result,
    input  logic [ARQ-1:0]    ex_store_data,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_wb_en,
    input  logic              ex_pc_en,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [ARQ-1:0]    dm_wdata,
    input  logic              dm_gnt,
    input  logic              dm_rvalid,
    input  logic [ARQ-1:0]    dm_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_mux_contrl,
    output logic              wb_enable,
    output logic              wb_pc_en,
    output logic [REG_W-1:0]  wb_rd,
    output logic [ARQ-1:0]    wb_alu_result,
    output logic [ARQ-1:0]    wb_mem_result
);

    if (ADDR_W > ARQ) begin : g_addr_w_check
        $error("mem_stage_pipe: ADDR_W (%0d) must not exceed ARQ (%0d)", ADDR_W, ARQ);
    end

    mem_op_t ex_op_e;
    mem_op_t op_q;
    logic    accept;
    logic    capture;

    assign ex_op_e = mem_op_t'(ex_op);

    mem_stage_fsm u_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .ex_valid  (ex_valid),
        .ex_op     (ex_op_e),
        .held_op   (op_q),
        .wb_ready  (wb_ready),
        .dm_gnt    (dm_gnt),
        .dm_rvalid (dm_rvalid),
        .ex_ready  (ex_ready),
        .accept    (accept),
        .capture   (capture),
        .dm_req    (dm_req),
        .wb_valid  (wb_valid)
    );

    // Every field is captured at accept, so the WB bundle and the memory
    // payload both hold steady until the FSM moves past them.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset because they drive ports that must read 0 in reset.
        if (!rst_n) begin
            op_q          <= OP_PASS;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_wdata      <= '0;
            wb_mux_contrl <= 1'b0;
            wb_enable     <= 1'b0;
            wb_pc_en      <= 1'b0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_mem_result <= '0;
        end else if (accept) begin
            op_q          <= ex_op_e;
            dm_we         <= (ex_op_e == OP_STORE);
            dm_addr       <= ex_alu_result[ADDR_W-1:0];
            dm_wdata      <= ex_store_data;
            wb_mux_contrl <= 1'b0;
            wb_enable     <= ex_wb_en && (ex_op_e != OP_STORE);
            wb_pc_en      <= ex_pc_en;
            wb_rd         <= ex_rd;
            wb_alu_result <= ex_alu_result;
            wb_mem_result <= '0;
        end else if (capture) begin
            wb_mux_contrl <= 1'b1;
            wb_mem_result <= dm_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Self-checking bench for mem_stage_pipe: directed scenarios, then random
// traffic scored against a transaction-level model with its own memory array.
module tb_mem_stage_pipe;

    localparam logic [1:0] P_PASS  = 2'd0;
    localparam logic [1:0] P_LOAD  = 2'd1;
    localparam logic [1:0] P_STORE = 2'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [1:0]  ex_op;
    logic [15:0] ex_alu_result;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_rd;
    logic        ex_wb_en;
    logic        ex_pc_en;
    logic        dm_req;
    logic        dm_we;
    logic [12:0] dm_addr;
    logic [15:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [15:0] dm_rdata;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_mux_contrl;
    logic        wb_enable;
    logic        wb_pc_en;
    logic [3:0]  wb_rd;
    logic [15:0] wb_alu_result;
    logic [15:0] wb_mem_result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.ARQ(16), .ADDR_W(13), .REG_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_op         (ex_op),
        .ex_alu_result (ex_alu_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_wb_en      (ex_wb_en),
        .ex_pc_en      (ex_pc_en),
        .dm_req        (dm_req),
        .dm_we         (dm_we),
        .dm_addr       (dm_addr),
        .dm_wdata      (dm_wdata),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .wb_valid      (wb_valid),
        .wb_ready      (wb_ready),
        .wb_mux_contrl (wb_mux_contrl),
        .wb_enable     (wb_enable),
        .wb_pc_en      (wb_pc_en),
        .wb_rd         (wb_rd),
        .wb_alu_result (wb_alu_result),
        .wb_mem_result (wb_mem_result)
    );

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] alu;
        logic [15:0] sd;
        logic [3:0]  rd;
        logic        wb_en;
        logic        pc_en;
    } op_t;

    op_t         exp_q[$];
    logic [15:0] mem_model [8192];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] dut_bundle();
        return {24'd0, wb_valid, wb_mux_contrl, wb_enable, wb_pc_en, wb_rd,
                wb_alu_result, wb_mem_result};
    endfunction

    function automatic logic [63:0] mk_bundle(input logic mux, input logic en, input logic pc,
                                              input logic [3:0] rd, input logic [15:0] alu,
                                              input logic [15:0] mres);
        return {24'd0, 1'b1, mux, en, pc, rd, alu, mres};
    endfunction

    // Expected WB bundle from the op's own fields and the model memory.
    function automatic logic [63:0] exp_bundle(input op_t o);
        logic [15:0] mres;
        mres = (o.op == P_LOAD) ? mem_model[o.alu[12:0]] : 16'd0;
        return mk_bundle(o.op == P_LOAD, o.wb_en && (o.op != P_STORE), o.pc_en, o.rd, o.alu, mres);
    endfunction

    task automatic present(input logic [1:0] op, input logic [15:0] alu, input logic [15:0] sd,
                           input logic [3:0] rd, input logic wen, input logic pen);
        ex_valid      = 1'b1;
        ex_op         = op;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_rd         = rd;
        ex_wb_en      = wen;
        ex_pc_en      = pen;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        op_t         pend;
        logic        pend_v;
        int          rv_cnt;
        logic [12:0] rv_addr;
        logic        stall_prev, req_prev, pass_prev;
        logic [63:0] snap;
        int          wait_cnt;
        int          d;

        rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_op = P_PASS;
        ex_alu_result = '0; ex_store_data = '0; ex_rd = '0; ex_wb_en = 1'b0; ex_pc_en = 1'b0;
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 16'hA5A5; wb_ready = 1'b0;

        // Reset with a stray rvalid on the bus
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb", dut_bundle(), 64'd0);
        check("rst_dm", {dm_req, dm_we, dm_addr, dm_wdata}, 64'd0);
        check("rst_rdy", ex_ready, 1);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            check("post_rst_v", wb_valid, 0);
        end
        dm_rvalid = 1'b0;

        // PASS back-to-back
        wb_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(P_PASS, 16'(17 + i), 16'h0, 4'd1, 1'b1, 1'b0);
            #1 check("pass_rdy", ex_ready, 1);
            next_cycle();
            check("pass_wb", dut_bundle(), mk_bundle(1'b0, 1'b1, 1'b0, 4'd1, 16'(17 + i), 16'd0));
        end
        ex_valid = 1'b0;
        next_cycle();
        check("pass_end_v", wb_valid, 0);

        // LOAD with delayed grant and delayed rvalid
        present(P_LOAD, 16'h0005, 16'h0, 4'd7, 1'b1, 1'b0);
        #1 check("ld_rdy", ex_ready, 1);
        next_cycle();
        ex_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("ld_req", {dm_req, dm_we, dm_addr}, {1'b1, 1'b0, 13'h0005});
            if (k == 2) dm_gnt = 1'b1;
            next_cycle();
        end
        dm_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("ld_wait_v", {wb_valid, dm_req}, 0);
            if (k == 2) begin
                dm_rvalid = 1'b1;
                dm_rdata  = 16'hBEEF;
            end
            next_cycle();
        end
        dm_rvalid = 1'b0;
        check("ld_wb", dut_bundle(), mk_bundle(1'b1, 1'b1, 1'b0, 4'd7, 16'h0005, 16'hBEEF));
        next_cycle();
        check("ld_end_v", wb_valid, 0);

        // STORE with upper alu bits set, then held under backpressure
        wb_ready = 1'b0;
        present(P_STORE, 16'hFFFF, 16'h1234, 4'd3, 1'b1, 1'b1);
        next_cycle();
        ex_valid = 1'b0;
        check("st_req", {dm_req, dm_we, dm_addr, dm_wdata}, {1'b1, 1'b1, 13'h1FFF, 16'h1234});
        dm_gnt = 1'b1;
        next_cycle();
        dm_gnt = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("st_hold_wb", dut_bundle(), mk_bundle(1'b0, 1'b0, 1'b1, 4'd3, 16'hFFFF, 16'd0));
            present(P_PASS, 16'h0055, 16'h0, 4'd9, 1'b0, 1'b0);
            #1 check("st_hold_rdy", ex_ready, 0);
            next_cycle();
        end
        wb_ready = 1'b1;
        #1 check("bp_release_rdy", ex_ready, 1);
        next_cycle();
        ex_valid = 1'b0;
        check("bp_next_wb", dut_bundle(), mk_bundle(1'b0, 1'b0, 1'b0, 4'd9, 16'h0055, 16'd0));
        next_cycle();
        check("bp_end_v", wb_valid, 0);

        // Flush while waiting for read data; stale 0xDEAD must be dropped
        present(P_LOAD, 16'h0010, 16'h0, 4'd2, 1'b1, 1'b0);
        next_cycle();
        ex_valid = 1'b0;
        dm_gnt = 1'b1;
        next_cycle();
        dm_gnt = 1'b0;
        flush = 1'b1;
        present(P_PASS, 16'h0077, 16'h0, 4'd4, 1'b1, 1'b0);
        #1 check("flush_rdy", ex_ready, 0);
        next_cycle();
        flush = 1'b0;
        ex_valid = 1'b0;
        check("flush_out", {wb_valid, dm_req}, 0);
        ex_op = P_LOAD;
        #1 check("drop_ld_rdy", ex_ready, 0);
        ex_op = P_STORE;
        #1 check("drop_st_rdy", ex_ready, 1);
        ex_op = P_PASS;
        #1 check("drop_pass_rdy", ex_ready, 1);
        dm_rvalid = 1'b1;
        dm_rdata  = 16'hDEAD;
        next_cycle();
        dm_rvalid = 1'b0;
        check("no_dead", {wb_valid, 15'd0, wb_mem_result == 16'hDEAD}, 0);
        present(P_LOAD, 16'h0020, 16'h0, 4'd5, 1'b1, 1'b1);
        #1 check("ld_rdy_after_drop", ex_ready, 1);
        next_cycle();
        ex_valid = 1'b0;
        dm_gnt = 1'b1;
        dm_rvalid = 1'b1;
        dm_rdata = 16'h0042;
        next_cycle();
        dm_gnt = 1'b0;
        dm_rvalid = 1'b0;
        check("ld_0wait_wb", dut_bundle(), mk_bundle(1'b1, 1'b1, 1'b1, 4'd5, 16'h0020, 16'h0042));
        next_cycle();
        check("ld_0wait_end", wb_valid, 0);

        // Flush in the grant cycle of a read: response still owed
        present(P_LOAD, 16'h0030, 16'h0, 4'd6, 1'b1, 1'b0);
        next_cycle();
        ex_valid = 1'b0;
        flush = 1'b1;
        dm_gnt = 1'b1;
        next_cycle();
        flush = 1'b0;
        dm_gnt = 1'b0;
        check("fg_out", {wb_valid, dm_req}, 0);
        ex_op = P_LOAD;
        #1 check("fg_ld_rdy", ex_ready, 0);
        next_cycle();
        dm_rvalid = 1'b1;
        dm_rdata = 16'hDEAD;
        next_cycle();
        dm_rvalid = 1'b0;
        check("fg_drop_v", wb_valid, 0);
        #1 check("fg_ld_rdy_after", ex_ready, 1);

        // Random traffic against the transaction-level model
        for (int i = 0; i < 8192; i++) mem_model[i] = 16'($urandom);
        pend = '0; pend_v = 1'b0; rv_cnt = 0; rv_addr = '0;
        stall_prev = 1'b0; req_prev = 1'b0; pass_prev = 1'b0; snap = '0; wait_cnt = 0;
        next_cycle();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (stall_prev) check("rnd_stall_wb", dut_bundle(), snap);
            if (req_prev)   check("rnd_req_hold", dm_req, 1);
            if (pass_prev)  check("rnd_pass_lat", wb_valid, 1);

            ex_valid      = ($urandom_range(0, 9) < 6);
            ex_op         = 2'($urandom_range(0, 2));
            ex_alu_result = {3'($urandom), 9'd0, 4'($urandom)};
            ex_store_data = 16'($urandom);
            ex_rd         = 4'($urandom);
            ex_wb_en      = 1'($urandom);
            ex_pc_en      = 1'($urandom);
            wb_ready      = ($urandom_range(0, 9) < 7);
            dm_gnt        = dm_req && ($urandom_range(0, 1) == 1);
            dm_rvalid     = 1'b0;
            dm_rdata      = 16'($urandom);

            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dm_rvalid = 1'b1;
                    dm_rdata  = mem_model[rv_addr];
                end
            end
            if (dm_gnt) begin
                check("rnd_gnt_pend", pend_v, 1);
                check("rnd_gnt_payload", {dm_we, dm_addr, dm_wdata},
                      {pend.op == P_STORE, pend.alu[12:0], (pend.op == P_STORE) ? pend.sd : dm_wdata});
                if (pend.op == P_STORE) begin
                    mem_model[pend.alu[12:0]] = pend.sd;
                end else begin
                    rv_addr = pend.alu[12:0];
                    d = $urandom_range(0, 3);
                    if (d == 0) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = mem_model[rv_addr];
                    end else begin
                        rv_cnt = d;
                    end
                end
                pend_v = 1'b0;
            end

            #1;
            if (exp_q.size() == 0) begin
                check("rnd_idle_rdy", ex_ready, 1);
                check("rnd_idle_v", wb_valid, 0);
            end
            if (wb_valid && !wb_ready) check("rnd_stall_rdy", ex_ready, 0);
            if (wb_valid && wb_ready && exp_q.size() > 0) begin
                check("rnd_wb", dut_bundle(), exp_bundle(exp_q.pop_front()));
                wait_cnt = 0;
            end
            pass_prev = 1'b0;
            if (ex_valid && ex_ready) begin
                op_t o;
                o = '{op: ex_op, alu: ex_alu_result, sd: ex_store_data,
                      rd: ex_rd, wb_en: ex_wb_en, pc_en: ex_pc_en};
                exp_q.push_back(o);
                if (ex_op == P_PASS) pass_prev = 1'b1;
                else begin
                    pend   = o;
                    pend_v = 1'b1;
                end
            end
            if (exp_q.size() > 0) wait_cnt++;
            if (wait_cnt > 60) begin
                check("rnd_timeout", 0, 1);
                wait_cnt = 0;
            end
            stall_prev = wb_valid && !wb_ready;
            req_prev   = dm_req && !dm_gnt;
            snap       = dut_bundle();
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
